// File: rtl/iter_alu_pkg.sv
// Shared opcode, state and helper definitions for the iterative ALU.
package iter_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_ADDN = 4'b0100,
        OP_ORN  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_LUI  = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_BLEZ = 4'b1010,
        OP_SRLV = 4'b1011,
        OP_SRL  = 4'b1100,
        OP_MUL  = 4'b1101,
        OP_DIVU = 4'b1110,
        OP_REMU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SIMPLE = 2'b01,
        BUSY   = 2'b10,
        DONE   = 2'b11
    } state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
module iter_muldiv
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc: product accumulator (MUL) or partial remainder (DIV)
    // x:   multiplier (MUL) or dividend shifting into quotient (DIV)
    // y:   shifted multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_q, acc_src, acc_nxt;
    logic [WIDTH-1:0] x_q, x_src, x_nxt;
    logic [WIDTH-1:0] y_q, y_src, y_nxt;
    logic             div_q, div_src;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   trial, diff;

    // The first step is applied on the start edge, straight from the operands,
    // so WIDTH steps complete after WIDTH edges.
    always_comb begin
        acc_src = start ? '0 : acc_q;
        x_src   = start ? a : x_q;
        y_src   = start ? b : y_q;
        div_src = start ? (op != OP_MUL) : div_q;
        trial   = {acc_src, x_src[WIDTH-1]};
        diff    = trial - {1'b0, y_src};
        acc_nxt = acc_src;
        x_nxt   = x_src;
        y_nxt   = y_src;
        if (div_src) begin
            // Remainder stays below the divisor, so the WIDTH+1-bit trial
            // always fits back into WIDTH bits after restoring.
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                x_nxt   = {x_src[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = trial[WIDTH-1:0];
                x_nxt   = {x_src[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = x_src[0] ? (acc_src + y_src) : acc_src;
            x_nxt   = x_src >> 1;
            y_nxt   = y_src << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start || (cnt_q != '0)) begin
            acc_q <= acc_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            div_q <= div_src;
            cnt_q <= start ? CW'(WIDTH - 1) : (cnt_q - CW'(1));
        end
    end

    assign done      = (cnt_q == '0);
    assign product   = acc_q;
    assign quotient  = x_q;
    assign remainder = acc_q;

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ops registered after one SIMPLE cycle,
// MUL/DIVU/REMU iterated in iter_muldiv; valid/ready on both sides.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid raised while ready is low is not remembered.
    state_e           state;
    logic [CW-1:0]    cnt;
    alu_op_e          op_q;
    alu_op_e          op_in;
    logic [WIDTH-1:0] a_q, b_q;
    logic [SHW-1:0]   sh_q;
    logic [WIDTH-1:0] simple_res, md_res;
    logic [WIDTH-1:0] md_prod, md_quot, md_rem;
    logic             md_done, md_start, accept;

    assign op_in     = alu_op_e'(alucontrol);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && is_multicycle(op_in);

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .op        (op_in),
        .a         (operand1),
        .b         (operand2),
        .done      (md_done),
        .product   (md_prod),
        .quotient  (md_quot),
        .remainder (md_rem)
    );

    always_comb begin
        simple_res = '0;
        case (op_q)
            OP_AND:  simple_res = a_q & b_q;
            OP_OR:   simple_res = a_q | b_q;
            OP_ADD:  simple_res = a_q + b_q;
            OP_SLL:  simple_res = b_q << sh_q;
            OP_ADDN: simple_res = a_q + ~b_q;
            OP_ORN:  simple_res = a_q | ~b_q;
            OP_SUB:  simple_res = a_q - b_q;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_LUI:  simple_res = b_q << (WIDTH / 2);
            OP_XOR:  simple_res = a_q ^ b_q;
            OP_BLEZ: simple_res = {{(WIDTH-1){1'b0}}, ~(a_q[WIDTH-1] | (a_q == '0))};
            OP_SRLV: simple_res = b_q >> a_q[SHW-1:0];
            OP_SRL:  simple_res = b_q >> sh_q;
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_MUL:  md_res = md_prod;
            OP_DIVU: md_res = md_quot;
            default: md_res = md_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_AND;
            a_q    <= '0;
            b_q    <= '0;
            sh_q   <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op_in;
                        a_q  <= operand1;
                        b_q  <= operand2;
                        sh_q <= shamt;
                        if (is_multicycle(op_in)) begin
                            state <= BUSY;
                            cnt   <= CW'(WIDTH);
                        end else begin
                            state <= SIMPLE;
                        end
                    end
                end
                SIMPLE: begin
                    result <= simple_res;
                    zero   <= (simple_res == '0);
                    state  <= DONE;
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    // Last decrement: the divider/multiplier has finished its WIDTH steps.
                    if ((cnt == CW'(1)) && md_done) begin
                        result <= md_res;
                        zero   <= (md_res == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Randomized scoreboard bench for iter_alu with directed corner cases.
module tb_iter_alu;

    localparam int W   = 32;
    localparam int SHW = 5;

    localparam logic [3:0] T_ADD  = 4'd2;
    localparam logic [3:0] T_SUB  = 4'd6;
    localparam logic [3:0] T_LUI  = 4'd8;
    localparam logic [3:0] T_BLEZ = 4'd10;
    localparam logic [3:0] T_SRLV = 4'd11;
    localparam logic [3:0] T_SRL  = 4'd12;
    localparam logic [3:0] T_MUL  = 4'd13;
    localparam logic [3:0] T_DIVU = 4'd14;
    localparam logic [3:0] T_REMU = 4'd15;

    // ---------------- clock / reset ----------------
    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic           in_valid   = 1'b0;
    logic           out_ready  = 1'b1;
    logic [3:0]     alucontrol = '0;
    logic [W-1:0]   operand1   = '0;
    logic [W-1:0]   operand2   = '0;
    logic [SHW-1:0] shamt      = '0;
    logic           in_ready, out_valid, zero;
    logic [W-1:0]   result;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    iter_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .operand1   (operand1),
        .operand2   (operand2),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];
    int           checks   = 0;
    int           failures = 0;
    bit           rand_bp  = 1'b0;
    bit           ready_force = 1'b1;
    bit           seen = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model straight from the opcode table.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [SHW-1:0] sh);
        logic [W-1:0] r;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = b << sh;
            4'd4:  r = a + ~b;
            4'd5:  r = a | ~b;
            4'd6:  r = a - b;
            4'd7:  r = (a < b) ? 1 : 0;
            4'd8:  r = b << (W / 2);
            4'd9:  r = a ^ b;
            4'd10: r = ($signed(a) > 0) ? 1 : 0;
            4'd11: r = b >> (a % W);
            4'd12: r = b >> sh;
            4'd13: r = a * b;
            4'd14: r = (b == 0) ? '1 : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // out_ready is owned by one process: random backpressure or a forced level.
    always @(posedge clk) begin
        #1;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", result);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", W'(cycle - acc_q[0] + 1), W'(lat_q[0]));
                end
                check("result", result, exp_q[0]);
                check("zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, (exp_q[0] == '0)});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=%0d required=1", in_ready);
            return;
        end
        in_valid   = 1'b1;
        alucontrol = op;
        operand1   = a;
        operand2   = b;
        shamt      = sh;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        operand1   = $urandom;
        operand2   = $urandom;
        shamt      = SHW'($urandom_range(0, W - 1));
        alucontrol = 4'($urandom_range(0, 15));
        exp_q.push_back(model(op, a, b, sh));
        lat_q.push_back((op >= T_MUL) ? (W + 1) : 2);
        acc_q.push_back(cycle);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit bad;
        int guard;
        logic [3:0]     op;
        logic [W-1:0]   a, b;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_result", result, '0);
        check("reset_zero", {{(W-1){1'b0}}, zero}, '0);
        check("reset_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("reset_in_ready", {{(W-1){1'b0}}, in_ready}, 1);

        issue(T_ADD, 5, 7, 0);
        issue(T_SUB, 5, 5, 0);
        drain();

        issue(T_MUL, 32'hFFFF_FFFF, 3, 0);
        bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (in_ready) bad = 1'b1;
        end
        check("mul_in_ready_low", {{(W-1){1'b0}}, bad}, '0);
        drain();

        issue(T_DIVU, 100, 7, 0);
        issue(T_REMU, 100, 7, 0);
        issue(T_DIVU, 100, 0, 0);
        issue(T_REMU, 100, 0, 0);
        issue(T_SRLV, 32'h25, 32'hFFFF_FFFF, 0);
        issue(T_LUI, 0, 32'h1234, 0);
        drain();

        // Stall in DONE; an in_valid pulse during the stall must be dropped.
        ready_force = 1'b0;
        @(posedge clk);
        issue(T_SRL, 0, 32'h8000_0000, 4);
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reached_done", {{(W-1){1'b0}}, out_valid}, 1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid   = (i == 2);
            alucontrol = T_ADD;
            operand1   = 1;
            operand2   = 1;
            @(negedge clk);
            if (in_ready) bad = 1'b1;
        end
        check("stall_in_ready_low", {{(W-1){1'b0}}, bad}, '0);
        in_valid    = 1'b0;
        ready_force = 1'b1;
        drain();

        // Reset in the middle of a MUL abandons it.
        issue(T_MUL, $urandom, $urandom, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("midreset_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
        check("midreset_result", result, '0);
        issue(T_BLEZ, 32'h8000_0000, 0, 0);
        drain();

        // Random traffic with random backpressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            issue(op, a, b, SHW'($urandom_range(0, W - 1)));
        end
        @(negedge clk);
        rand_bp = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=%0d required=finished", cycle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
